// File: rtl/traffic_pkg.sv
// Shared types and constants for the roadside sensor front end.
package traffic_pkg;
  localparam int DEFAULT_NUM_LANES = 4;
  localparam int DENSITY_W         = 3;
  localparam logic [DENSITY_W-1:0] DENSITY_MAX = 3'd7;

  typedef logic [DENSITY_W-1:0] density_t;
  typedef enum logic [1:0] {IDLE, CONFIRM, ACTIVE, HOLD} emerg_state_e;

  // Count plus an optional event, pinned at DENSITY_MAX instead of wrapping.
  function automatic density_t sat_inc(density_t c, logic inc);
    return (inc && (c != DENSITY_MAX)) ? density_t'(c + 1'b1) : c;
  endfunction
endpackage

// File: rtl/traffic_lane_sensor.sv
// One lane: input synchronisers, IR debounce with per-window vehicle count,
// and the siren confirm/hold state machine.
module traffic_lane_sensor
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EMERG_CONFIRM   = 64,
  parameter int EMERG_HOLD      = 500
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     ir_raw,
  input  logic     sound_raw,
  input  logic     window_wrap,
  output density_t density,
  output logic     emergency
);
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int EM_MAX = (EMERG_CONFIRM > EMERG_HOLD) ? EMERG_CONFIRM : EMERG_HOLD;
  localparam int EM_W   = $clog2(EM_MAX + 1);

  logic [1:0] ir_sync, snd_sync;
  logic       ir_s, snd_s;
  assign ir_s  = ir_sync[1];
  assign snd_s = snd_sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_sync  <= '0;
      snd_sync <= '0;
    end else begin
      ir_sync  <= {ir_sync[0], ir_raw};
      snd_sync <= {snd_sync[0], sound_raw};
    end
  end

  logic [DB_W-1:0] db_cnt;
  logic            ir_deb, deb_flip, veh_evt;
  assign deb_flip = (ir_s != ir_deb) && (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
  assign veh_evt  = deb_flip && ir_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt <= '0;
      ir_deb <= 1'b0;
    end else if (ir_s == ir_deb) begin
      db_cnt <= '0;
    end else if (deb_flip) begin
      db_cnt <= '0;
      ir_deb <= ir_s;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // density is the value this window closes with, so a wrap-cycle event is included.
  density_t veh_cnt;
  assign density = sat_inc(veh_cnt, veh_evt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) veh_cnt <= '0;
    else       veh_cnt <= window_wrap ? '0 : density;
  end

  emerg_state_e    state, state_nx;
  logic [EM_W-1:0] ctr, ctr_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ctr       <= '0;
      emergency <= 1'b0;
    end else begin
      state     <= state_nx;
      ctr       <= ctr_nx;
      emergency <= (state_nx == ACTIVE) || (state_nx == HOLD);
    end
  end

  always_comb begin
    state_nx = state;
    ctr_nx   = ctr;
    unique case (state)
      IDLE:
        if (snd_s) begin
          state_nx = (EMERG_CONFIRM == 1) ? ACTIVE : CONFIRM;
          ctr_nx   = EM_W'(1);
        end
      CONFIRM:
        if (!snd_s) begin
          state_nx = IDLE;
          ctr_nx   = '0;
        end else begin
          ctr_nx = ctr + 1'b1;
          if (ctr == EM_W'(EMERG_CONFIRM - 1)) state_nx = ACTIVE;
        end
      ACTIVE:
        if (!snd_s) begin
          state_nx = (EMERG_HOLD == 1) ? IDLE : HOLD;
          ctr_nx   = EM_W'(1);
        end
      HOLD:
        if (snd_s) begin
          state_nx = ACTIVE;
        end else if (ctr == EM_W'(EMERG_HOLD - 1)) begin
          state_nx = IDLE;
          ctr_nx   = '0;
        end else begin
          ctr_nx = ctr + 1'b1;
        end
      default: begin
        state_nx = IDLE;
        ctr_nx   = '0;
      end
    endcase
  end
endmodule

// File: rtl/traffic_sensor_frontend.sv
// Sensor front end: per-lane conditioning plus the shared sampling window that
// publishes IR density words and a one-cycle sample_valid strobe.
module traffic_sensor_frontend
  import traffic_pkg::*;
#(
  parameter int NUM_LANES       = DEFAULT_NUM_LANES,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int WINDOW_CYCLES   = 1000,
  parameter int EMERG_CONFIRM   = 64,
  parameter int EMERG_HOLD      = 500
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_LANES-1:0]           ir_raw,
  input  logic [NUM_LANES-1:0]           sound_raw,
  output logic [DENSITY_W*NUM_LANES-1:0] IR_sensors,
  output logic [NUM_LANES-1:0]           sound_sensors,
  output logic                           sample_valid
);
  localparam int WIN_W = $clog2(WINDOW_CYCLES);

  logic [WIN_W-1:0]            win_cnt;
  logic                        window_wrap;
  density_t [NUM_LANES-1:0]    lane_density;

  assign window_wrap = (win_cnt == WIN_W'(WINDOW_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) win_cnt <= '0;
    else       win_cnt <= window_wrap ? '0 : win_cnt + 1'b1;
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    traffic_lane_sensor #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .EMERG_CONFIRM   (EMERG_CONFIRM),
      .EMERG_HOLD      (EMERG_HOLD)
    ) u_lane (
      .clk         (clk),
      .reset       (reset),
      .ir_raw      (ir_raw[i]),
      .sound_raw   (sound_raw[i]),
      .window_wrap (window_wrap),
      .density     (lane_density[i]),
      .emergency   (sound_sensors[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      IR_sensors   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= window_wrap;
      if (window_wrap) IR_sensors <= lane_density;
    end
  end
endmodule

// File: tb/tb_traffic_sensor_frontend.sv
// Randomised + directed bench: expected outputs are derived from pulse/burst
// descriptions, queued per cycle, and compared by an independent monitor.
module tb_traffic_sensor_frontend;
  localparam int NL   = 4;
  localparam int DEB  = 2;
  localparam int WIN  = 32;
  localparam int EC   = 4;
  localparam int EH   = 8;
  localparam int NWIN = 24;
  localparam int NCYC = NWIN * WIN;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NL-1:0]     ir_raw = '1;
  logic [NL-1:0]     sound_raw = '1;
  logic [3*NL-1:0]   IR_sensors;
  logic [NL-1:0]     sound_sensors;
  logic              sample_valid;

  traffic_sensor_frontend #(
    .NUM_LANES(NL), .DEBOUNCE_CYCLES(DEB), .WINDOW_CYCLES(WIN),
    .EMERG_CONFIRM(EC), .EMERG_HOLD(EH)
  ) dut (
    .clk(clk), .reset(reset), .ir_raw(ir_raw), .sound_raw(sound_raw),
    .IR_sensors(IR_sensors), .sound_sensors(sound_sensors), .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  // wave[e] is the pin value sampled by rising edge e (edge 1 = first after reset release)
  logic [NL-1:0]   ir_wave  [0:NCYC];
  logic [NL-1:0]   snd_wave [0:NCYC];
  logic [NL-1:0]   exp_snd  [0:NCYC];
  int              win_evts [NWIN][NL];
  logic [3*NL-1:0] ir_q [$];
  logic [NL-1:0]   snd_q [$];
  logic [3*NL-1:0] last_ir = '0;
  int              checks = 0;
  int              passes = 0;
  int              edge_cnt = 0;

  always @(posedge clk) if (!reset) edge_cnt <= edge_cnt + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Clean pulse: debounced rise lands DEB+1 edges after the first high sample.
  task automatic add_pulse(input int lane, input int t0, input int w);
    for (int t = t0; t < t0 + w; t++) if (t <= NCYC) ir_wave[t][lane] = 1'b1;
    if (t0 + DEB + 1 <= NCYC) win_evts[(t0 + DEB) / WIN][lane]++;
  endtask

  task automatic add_snd(input int lane, input int t0, input int w);
    for (int t = t0; t < t0 + w; t++) if (t <= NCYC) snd_wave[t][lane] = 1'b1;
  endtask

  function automatic logic [3*NL-1:0] exp_ir_word(input int w);
    logic [3*NL-1:0] r;
    r = '0;
    for (int l = 0; l < NL; l++)
      r[3*l +: 3] = (win_evts[w][l] > 7) ? 3'd7 : 3'(win_evts[w][l]);
    return r;
  endfunction

  task automatic build_stimulus();
    int t, w;
    for (int e = 0; e <= NCYC; e++) begin
      ir_wave[e] = '0;
      snd_wave[e] = '0;
    end
    for (int i = 0; i < NWIN; i++) for (int l = 0; l < NL; l++) win_evts[i][l] = 0;
    // window 0: three 6/6 pulses on lane 1, a single-cycle glitch on lane 0
    for (int p = 0; p < 3; p++) add_pulse(1, 2 + 12 * p, 6);
    ir_wave[10][0] = 1'b1;
    // lane 3: ten tightest clean pulses straddling windows 2 and 3 (saturates window 2)
    for (int p = 0; p < 10; p++) add_pulse(3, 64 + 4 * p, DEB);
    // all lanes pulse together while lanes 0 and 2 carry sirens
    for (int l = 0; l < NL; l++) for (int p = 0; p < 3; p++) add_pulse(l, 140 + 2 * l + 6 * p, 3);
    add_snd(0, 4, 3);              // too short to confirm
    add_snd(0, 20, 4);             // exactly long enough, then full hold expiry
    add_snd(2, 110, 11);
    add_snd(2, 126, 10);           // retrigger during hold
    add_snd(0, 150, 26);
    add_snd(2, 150, 26);
    // randomised tail
    for (int l = 0; l < NL; l++) begin
      t = 193 + int'($urandom_range(0, 5));
      while (t < NCYC - 40) begin
        if ($urandom_range(0, 4) == 0) begin
          ir_wave[t][l] = 1'b1;
          t += 1 + int'($urandom_range(3, 7));
        end else begin
          w = int'($urandom_range(DEB, 6));
          add_pulse(l, t, w);
          t += w + int'($urandom_range(3, 7));
        end
      end
      t = 193 + int'($urandom_range(0, 9));
      while (t < NCYC - 40) begin
        w = int'($urandom_range(1, 12));
        add_snd(l, t, w);
        t += w + int'($urandom_range(1, 14));
      end
    end
  endtask

  // Emergency is set once EC consecutive synced siren samples have been seen
  // and cleared after EH consecutive silent ones; synced sample at edge e is pin at e-2.
  task automatic build_sound_model();
    int ones, zeros;
    logic act, s;
    for (int l = 0; l < NL; l++) begin
      ones = 0; zeros = 0; act = 1'b0;
      exp_snd[0][l] = 1'b0;
      for (int e = 1; e <= NCYC; e++) begin
        s = (e >= 3) ? snd_wave[e-2][l] : 1'b0;
        if (s) begin ones++; zeros = 0; end
        else   begin zeros++; ones = 0; end
        if (ones >= EC) act = 1'b1;
        if (zeros >= EH) act = 1'b0;
        exp_snd[e][l] = act;
      end
    end
  endtask

  // Driver
  initial begin
    build_stimulus();
    build_sound_model();
    repeat (4) begin
      @(negedge clk);
      check("rst_ir", 32'(IR_sensors), 32'h0);
      check("rst_snd", 32'(sound_sensors), 32'h0);
      check("rst_vld", 32'(sample_valid), 32'h0);
    end
    for (int e = 1; e <= NCYC; e++) begin
      @(negedge clk);
      reset = 1'b0;
      ir_raw = ir_wave[e];
      sound_raw = snd_wave[e];
      snd_q.push_back(exp_snd[e]);
      if (e % WIN == 0) ir_q.push_back(exp_ir_word(e / WIN - 1));
    end
    @(negedge clk);
    @(negedge clk);
    check("queues_drained", 32'(ir_q.size() + snd_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Monitor
  initial forever begin
    logic [NL-1:0]   es;
    logic [3*NL-1:0] ei;
    @(negedge clk);
    if (!reset && edge_cnt >= 1 && edge_cnt <= NCYC) begin
      if (snd_q.size() == 0) check("snd_q_underflow", 32'(snd_q.size()), 32'h1);
      else begin
        es = snd_q.pop_front();
        check($sformatf("sound@%0d", edge_cnt), 32'(sound_sensors), 32'(es));
      end
      if (edge_cnt % WIN == 0) begin
        check($sformatf("valid@%0d", edge_cnt), 32'(sample_valid), 32'h1);
        if (ir_q.size() == 0) check("ir_q_underflow", 32'(ir_q.size()), 32'h1);
        else begin
          ei = ir_q.pop_front();
          check($sformatf("density_win%0d", edge_cnt / WIN - 1), 32'(IR_sensors), 32'(ei));
          last_ir = ei;
        end
      end else begin
        check($sformatf("novalid@%0d", edge_cnt), 32'(sample_valid), 32'h0);
        if (edge_cnt % WIN == WIN / 2)
          check($sformatf("ir_stable@%0d", edge_cnt), 32'(IR_sensors), 32'(last_ir));
      end
    end
  end
endmodule
